// File: rtl/alu_pkg.sv
// Shared ALU definitions: NZVC bit positions, opcode encodings and the commit entry type.
// Used by the commit stage, its buffer and the bench.
package alu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam int unsigned N_BIT = 3;
  localparam int unsigned Z_BIT = 2;
  localparam int unsigned V_BIT = 1;
  localparam int unsigned C_BIT = 0;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_INC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [3:0]        nzvc;
    logic [2:0]        sel;
  } entry_t;

  // Logic ops never produce overflow or carry.
  function automatic logic is_logic_op(logic [2:0] sel);
    return sel >= OP_AND;
  endfunction

endpackage

// File: rtl/alu_commit_stage_if.sv
// Handshake bundle between the ALU (producer), the commit stage and the writeback port.
// The stage uses the slave view; the driving environment uses the master view.
interface alu_commit_stage_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [3:0]       in_nzvc;
  logic [2:0]       in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_nzvc;
  logic [2:0]       out_sel;

  modport master (
    output in_valid, in_result, in_nzvc, in_sel, out_ready,
    input  in_ready, out_valid, out_result, out_nzvc, out_sel
  );

  modport slave (
    input  in_valid, in_result, in_nzvc, in_sel, out_ready,
    output in_ready, out_valid, out_result, out_nzvc, out_sel
  );
endinterface

// File: rtl/alu_commit_fifo.sv
// In-order DEPTH-entry result buffer with wrapping pointers and an occupancy count.
// Storage is reset so the head fields read as zero out of reset.
module alu_commit_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [OCC_W-1:0]   occ_q;
  logic               do_push, do_pop;

  assign full    = (occ_q == OCC_W'(DEPTH));
  assign empty   = (occ_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_commit_stage.sv
// Commit stage after the ALU: buffers results, presents them to writeback in order and
// tracks CCR, sticky V/C, a commit counter and a sticky flag-consistency error.
module alu_commit_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_commit_stage_if.slave   bus,
  input  logic                clr_sticky,
  output logic [3:0]          ccr,
  output logic                sticky_v,
  output logic                sticky_c,
  output logic                flag_err,
  output logic [CNT_W-1:0]    commit_cnt
);
  entry_t           wdata, head;
  logic             full, empty;
  logic             push, pop;
  logic             ready_q;
  logic             chk_err;
  logic [3:0]       ccr_q, ccr_d;
  logic             sticky_v_q, sticky_v_d;
  logic             sticky_c_q, sticky_c_d;
  logic             flag_err_q, flag_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ready_q holds in_ready low while in reset and through the release cycle.
  assign bus.in_ready  = ready_q & ~full;
  assign bus.out_valid = ~empty;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  assign wdata.result = bus.in_result;
  assign wdata.nzvc   = bus.in_nzvc;
  assign wdata.sel    = bus.in_sel;

  assign bus.out_result = head.result;
  assign bus.out_nzvc   = head.nzvc;
  assign bus.out_sel    = head.sel;

  alu_commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign chk_err = (bus.in_nzvc[Z_BIT] != (bus.in_result == '0))
                 | (bus.in_nzvc[N_BIT] != bus.in_result[WIDTH-1])
                 | (is_logic_op(bus.in_sel) & (bus.in_nzvc[V_BIT] | bus.in_nzvc[C_BIT]));

  // A clear wipes the old sticky state first, then this cycle's events are ORed in.
  always_comb begin
    ccr_d      = ccr_q;
    cnt_d      = cnt_q;
    sticky_v_d = clr_sticky ? 1'b0 : sticky_v_q;
    sticky_c_d = clr_sticky ? 1'b0 : sticky_c_q;
    flag_err_d = (clr_sticky ? 1'b0 : flag_err_q) | (push & chk_err);
    if (pop) begin
      ccr_d      = head.nzvc;
      cnt_d      = cnt_q + CNT_W'(1);
      sticky_v_d = sticky_v_d | head.nzvc[V_BIT];
      sticky_c_d = sticky_c_d | head.nzvc[C_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      ccr_q      <= '0;
      cnt_q      <= '0;
      sticky_v_q <= 1'b0;
      sticky_c_q <= 1'b0;
      flag_err_q <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      ccr_q      <= ccr_d;
      cnt_q      <= cnt_d;
      sticky_v_q <= sticky_v_d;
      sticky_c_q <= sticky_c_d;
      flag_err_q <= flag_err_d;
    end
  end

  assign ccr        = ccr_q;
  assign sticky_v   = sticky_v_q;
  assign sticky_c   = sticky_c_q;
  assign flag_err   = flag_err_q;
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_alu_commit_stage.sv
// Scoreboard bench for alu_commit_stage: stimulus queues expected entries, a monitor
// compares every commit, and the main thread checks CCR/sticky/counter state directly.
module tb_alu_commit_stage;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_sticky = 1'b0;
  logic [3:0]       ccr;
  logic             sticky_v, sticky_c, flag_err;
  logic [CNT_W-1:0] commit_cnt;

  alu_commit_stage_if #(.WIDTH(WIDTH)) bus ();

  alu_commit_stage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .ccr        (ccr),
    .sticky_v   (sticky_v),
    .sticky_c   (sticky_c),
    .flag_err   (flag_err),
    .commit_cnt (commit_cnt)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  int     pops = 0;
  entry_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] res, input logic [3:0] nzvc, input logic [2:0] sel);
    int budget = 20;
    bus.in_valid  = 1'b1;
    bus.in_result = res;
    bus.in_nzvc   = nzvc;
    bus.in_sel    = sel;
    while (bus.in_ready !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=%b, expected 1", bus.in_ready);
    end else begin
      exp_q.push_back(entry_t'{result: res, nzvc: nzvc, sel: sel});
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  // Commit monitor: every accepted head must match the oldest expected entry.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit: got 0x%0h, expected no commit", bus.out_result);
        end else begin
          e = exp_q.pop_front();
          check("commit_result", 32'(bus.out_result), 32'(e.result));
          check("commit_nzvc", 32'(bus.out_nzvc), 32'(e.nzvc));
          check("commit_sel", 32'(bus.out_sel), 32'(e.sel));
          pops++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_nzvc   = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_result", 32'(bus.out_result), 0);
    check("rst_ccr", 32'(ccr), 0);
    check("rst_cnt", 32'(commit_cnt), 0);
    check("rst_flag_err", 32'(flag_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", 32'(bus.in_ready), 1);

    // Single push then commit: 100+30 = 0x82, N=1 V=1
    bus.out_ready = 1'b1;
    send(8'h82, 4'b1010, OP_ADD);
    check("t1_out_valid", 32'(bus.out_valid), 1);
    check("t1_head", 32'(bus.out_result), 32'h82);
    tick();
    check("t1_ccr", 32'(ccr), 32'b1010);
    check("t1_sticky_v", 32'(sticky_v), 1);
    check("t1_sticky_c", 32'(sticky_c), 0);
    check("t1_cnt", 32'(commit_cnt), 1);
    check("t1_flag_err", 32'(flag_err), 0);
    check("t1_empty", 32'(bus.out_valid), 0);

    // Backpressure fills the buffer
    bus.out_ready = 1'b0;
    send(8'hEC, 4'b1000, OP_ADD);
    send(8'h06, 4'b0000, OP_ADD);
    check("t2_in_ready_full", 32'(bus.in_ready), 0);
    check("t2_head", 32'(bus.out_result), 32'hEC);
    tick();
    check("t2_head_stable", 32'(bus.out_result), 32'hEC);
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("t2_ccr", 32'(ccr), 32'b0000);
    check("t2_cnt", 32'(commit_cnt), 3);
    check("t2_drained", 32'(bus.out_valid), 0);

    // Streaming: one push and one commit per cycle
    for (int i = 1; i <= 10; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_result = 8'(i);
      bus.in_nzvc   = 4'b0000;
      bus.in_sel    = OP_ADD;
      check("t3_in_ready", 32'(bus.in_ready), 1);
      if (i > 1) check("t3_out_valid", 32'(bus.out_valid), 1);
      exp_q.push_back(entry_t'{result: 8'(i), nzvc: 4'b0000, sel: OP_ADD});
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    check("t3_cnt", 32'(commit_cnt), 13);
    check("t3_drained", 32'(exp_q.size()), 0);

    // Flag error: zero result with Z clear
    send(8'h00, 4'b0000, OP_AND);
    check("t4_flag_err", 32'(flag_err), 1);
    tick();
    check("t4_cnt", 32'(commit_cnt), 14);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("t4_clr_flag_err", 32'(flag_err), 0);
    check("t4_clr_sticky_v", 32'(sticky_v), 0);
    check("t4_clr_sticky_c", 32'(sticky_c), 0);
    check("t4_cnt_kept", 32'(commit_cnt), 14);

    // Clear coinciding with a commit
    send(8'h00, 4'b0101, OP_ADD);
    tick();
    check("t5_sticky_c_set", 32'(sticky_c), 1);
    send(8'h7F, 4'b0010, OP_SUB);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("t5_sticky_c", 32'(sticky_c), 0);
    check("t5_sticky_v", 32'(sticky_v), 1);
    check("t5_ccr", 32'(ccr), 32'b0010);
    check("t5_cnt", 32'(commit_cnt), 16);
    check("t5_pops", 32'(pops), 16);

    // Asynchronous reset with two entries buffered
    bus.out_ready = 1'b0;
    send(8'h11, 4'b0000, OP_ADD);
    send(8'h22, 4'b0000, OP_ADD);
    check("t6_full", 32'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_out_valid", 32'(bus.out_valid), 0);
    check("t6_ccr", 32'(ccr), 0);
    check("t6_cnt_rst", 32'(commit_cnt), 0);
    check("t6_in_ready_rst", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("t6_in_ready", 32'(bus.in_ready), 1);
    check("t6_cnt", 32'(commit_cnt), 0);
    check("t6_empty", 32'(bus.out_valid), 0);
    tick();
    check("t6_pops", 32'(pops), 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
